// File: rtl/gpio_irq_pkg.sv
// Shared constants, register map and access-type decode for the GPIO edge interrupt block.
package gpio_irq_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DB_W_DEF  = 16;

    localparam logic [7:0] ADDR_IN      = 8'h00;
    localparam logic [7:0] ADDR_RISE_EN = 8'h04;
    localparam logic [7:0] ADDR_FALL_EN = 8'h08;
    localparam logic [7:0] ADDR_PEND    = 8'h0C;
    localparam logic [7:0] ADDR_DB_CNT  = 8'h10;

    typedef enum logic [1:0] {
        ACC_RO,
        ACC_RW,
        ACC_W1C,
        ACC_NONE
    } access_e;

    typedef enum logic [2:0] {
        REG_IN,
        REG_RISE_EN,
        REG_FALL_EN,
        REG_PEND,
        REG_DB_CNT,
        REG_NONE
    } reg_sel_e;

    // Byte-lane bits are masked so any address within a word selects that word.
    function automatic reg_sel_e reg_decode(input logic [7:0] addr);
        reg_sel_e sel;
        case (addr & 8'hFC)
            ADDR_IN:      sel = REG_IN;
            ADDR_RISE_EN: sel = REG_RISE_EN;
            ADDR_FALL_EN: sel = REG_FALL_EN;
            ADDR_PEND:    sel = REG_PEND;
            ADDR_DB_CNT:  sel = REG_DB_CNT;
            default:      sel = REG_NONE;
        endcase
        return sel;
    endfunction

    function automatic access_e reg_access(input reg_sel_e sel);
        access_e acc;
        case (sel)
            REG_IN:                               acc = ACC_RO;
            REG_RISE_EN, REG_FALL_EN, REG_DB_CNT: acc = ACC_RW;
            REG_PEND:                             acc = ACC_W1C;
            default:                              acc = ACC_NONE;
        endcase
        return acc;
    endfunction

endpackage

// File: rtl/gpio_irq_debounce.sv
// One pin: two-flop synchronizer followed by a saturating debounce counter and stable value.
module gpio_irq_debounce #(
    parameter int DB_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pin,
    input  logic [DB_W-1:0] db_cnt,
    output logic            stb_v
);

    logic            meta;
    logic            sync;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= pin;
            sync <= meta;
        end
    end

    // ">=" rather than "==" so lowering db_cnt mid-count releases the pin next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            stb_v <= 1'b0;
        end else if (sync == stb_v) begin
            cnt <= '0;
        end else if (cnt >= db_cnt) begin
            stb_v <= sync;
            cnt   <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + DB_W'(1);
        end
    end

endmodule

// File: rtl/gpio_edge_irq.sv
// GPIO edge interrupt controller: debounced inputs, rise/fall enables, W1C pending bits, bus regs.
module gpio_edge_irq
    import gpio_irq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DB_W  = DB_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pin_i,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic [7:0]       addr_i,
    input  logic [31:0]      dat_i,
    output logic [31:0]      dat_o,
    output logic             ack_o,
    output logic             irq_o
);

    logic [WIDTH-1:0] stb_v;
    logic [WIDTH-1:0] stb_v_q;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] pend_set;
    logic [WIDTH-1:0] pend_clr;
    logic [DB_W-1:0]  db_cnt;
    logic             req;
    logic             wr;
    reg_sel_e         sel;
    access_e          acc;
    logic [31:0]      rdata;
    logic             unused_dat;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_irq_debounce #(.DB_W(DB_W)) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .pin    (pin_i[i]),
            .db_cnt (db_cnt),
            .stb_v  (stb_v[i])
        );
    end

    assign req        = cyc_i & stb_i & ~ack_o;
    assign wr         = req & we_i;
    assign sel        = reg_decode(addr_i);
    assign acc        = reg_access(sel);
    assign unused_dat = ^dat_i;

    always_comb begin
        rdata = '0;
        case (sel)
            REG_IN:      rdata = 32'(stb_v);
            REG_RISE_EN: rdata = 32'(rise_en);
            REG_FALL_EN: rdata = 32'(fall_en);
            REG_PEND:    rdata = 32'(pend);
            REG_DB_CNT:  rdata = 32'(db_cnt);
            default:     rdata = '0;
        endcase
    end

    // Enables qualify at the moment of the edge; later enable writes never touch pend.
    assign pend_set = (stb_v & ~stb_v_q & rise_en) | (~stb_v & stb_v_q & fall_en);
    assign pend_clr = (wr && acc == ACC_W1C) ? dat_i[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_v_q <= '0;
            pend    <= '0;
        end else begin
            stb_v_q <= stb_v;
            pend    <= (pend & ~pend_clr) | pend_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_en <= '0;
            fall_en <= '0;
            db_cnt  <= '0;
        end else if (wr && acc == ACC_RW) begin
            case (sel)
                REG_RISE_EN: rise_en <= dat_i[WIDTH-1:0];
                REG_FALL_EN: fall_en <= dat_i[WIDTH-1:0];
                REG_DB_CNT:  db_cnt  <= dat_i[DB_W-1:0];
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_o <= 1'b0;
            dat_o <= '0;
        end else begin
            ack_o <= req;
            dat_o <= (req && !we_i) ? rdata : '0;
        end
    end

    assign irq_o = |pend;

endmodule

// File: tb/tb_gpio_edge_irq.sv
// Self-checking bench for gpio_edge_irq: directed scenarios plus randomized traffic vs a reference model.
module tb_gpio_edge_irq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pin = 8'h00;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic [31:0] dat = 32'h0;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        irq_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gpio_edge_irq #(.WIDTH(8), .DB_W(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_i  (pin),
        .cyc_i  (cyc),
        .stb_i  (stb),
        .we_i   (we),
        .addr_i (addr),
        .dat_i  (dat),
        .dat_o  (dat_o),
        .ack_o  (ack_o),
        .irq_o  (irq_o)
    );

    // Reference model: pin seen two edges late, stable value follows once the
    // synchronized pin has disagreed for DB_CNT+1 consecutive edges.
    logic [7:0]  m_meta, m_sync, m_in, m_in_last, m_rise, m_fall, m_pend;
    logic [15:0] m_db;
    int          m_run [8];
    logic        m_ack;
    logic [31:0] m_dat;

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a[7:2])
            6'd0: return {24'h0, m_in};
            6'd1: return {24'h0, m_rise};
            6'd2: return {24'h0, m_fall};
            6'd3: return {24'h0, m_pend};
            6'd4: return {16'h0, m_db};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_meta = 0; m_sync = 0; m_in = 0; m_in_last = 0;
        m_rise = 0; m_fall = 0; m_pend = 0; m_db = 0;
        m_ack = 0; m_dat = 0;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
    endtask

    task automatic model_step();
        logic [7:0]  set, clr;
        logic        req;
        logic [31:0] rdv;
        set = ((m_in & ~m_in_last) & m_rise) | ((~m_in & m_in_last) & m_fall);
        req = cyc && stb && !m_ack;
        rdv = m_read(addr);
        clr = (req && we && addr[7:2] == 6'd3) ? dat[7:0] : 8'h00;
        m_in_last = m_in;
        for (int i = 0; i < 8; i++) begin
            if (m_sync[i] != m_in[i]) begin
                m_run[i]++;
                if (m_run[i] > int'(m_db)) begin
                    m_in[i] = m_sync[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_sync = m_meta;
        m_meta = pin;
        m_pend = (m_pend & ~clr) | set;
        if (req && we) begin
            case (addr[7:2])
                6'd1: m_rise = dat[7:0];
                6'd2: m_fall = dat[7:0];
                6'd4: m_db = dat[15:0];
                default: ;
            endcase
        end
        m_ack = req;
        m_dat = (req && !we) ? rdv : 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic ak, output logic [31:0] exp_rd);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; dat = d;
        tick();
        ak = ack_o;
        rd = dat_o;
        exp_rd = m_dat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] rd, ex;
        logic ak;
        bus(1'b1, a, d, rd, ak, ex);
    endtask

    task automatic rdreg(input logic [7:0] a, output logic [31:0] rd, output logic ak);
        logic [31:0] ex;
        bus(1'b0, a, 32'h0, rd, ak, ex);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic ak;
        logic [7:0] regs [5] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10};
        checks++;
        if ({ack_o, irq_o, dat_o} !== 34'h0) begin
            failures++;
            $display("FAIL reset_outputs ack=%b irq=%b dat=%h expected all 0", ack_o, irq_o, dat_o);
        end
        foreach (regs[i]) begin
            rdreg(regs[i], rd, ak);
            checks++;
            if (ak !== 1'b1 || rd !== 32'h0) begin
                failures++;
                $display("FAIL reset_reg_%h ack=%b dat=%h expected ack=1 dat=0", regs[i], ak, rd);
            end
        end
    endtask

    task automatic test_rise_db0();
        logic [31:0] rd;
        logic ak;
        int n = 0;
        wr(8'h10, 32'd0);
        wr(8'h04, 32'h01);
        pin[0] = 1'b1;
        while (irq_o !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL rise_db0_latency cycles=%0d expected 4", n);
        end
        rdreg(8'h00, rd, ak);
        checks++;
        if (rd !== 32'h01) begin
            failures++;
            $display("FAIL rise_db0_in got=%h expected 01", rd);
        end
        rdreg(8'h0C, rd, ak);
        checks++;
        if (rd !== 32'h01 || irq_o !== 1'b1) begin
            failures++;
            $display("FAIL rise_db0_pend got=%h irq=%b expected 01 irq=1", rd, irq_o);
        end
        wr(8'h0C, 32'hFF);
    endtask

    task automatic test_debounce_glitch();
        logic [31:0] rd_in, rd_pend;
        logic ak;
        pin = 8'h00;
        wr(8'h10, 32'd10);
        wr(8'h04, 32'h08);
        repeat (20) tick();
        wr(8'h0C, 32'hFF);
        pin[3] = 1'b1;
        repeat (5) tick();
        pin[3] = 1'b0;
        repeat (20) tick();
        rdreg(8'h00, rd_in, ak);
        rdreg(8'h0C, rd_pend, ak);
        checks++;
        if (rd_in !== 32'h0 || rd_pend !== 32'h0) begin
            failures++;
            $display("FAIL glitch_rejected in=%h pend=%h expected 0 0", rd_in, rd_pend);
        end
        pin[3] = 1'b1;
        repeat (12) tick();
        checks++;
        if (irq_o !== 1'b0) begin
            failures++;
            $display("FAIL hold_early irq=%b expected 0 after 12 cycles", irq_o);
        end
        rdreg(8'h00, rd_in, ak);
        checks++;
        if (rd_in !== 32'h0 || irq_o !== 1'b1) begin
            failures++;
            $display("FAIL hold_edge in_at_12=%h irq_at_14=%b expected 00 and 1", rd_in, irq_o);
        end
        rdreg(8'h00, rd_in, ak);
        checks++;
        if (rd_in !== 32'h08) begin
            failures++;
            $display("FAIL hold_in got=%h expected 08", rd_in);
        end
        wr(8'h0C, 32'hFF);
    endtask

    task automatic test_w1c();
        logic [31:0] rd;
        logic ak;
        wr(8'h10, 32'd0);
        wr(8'h04, 32'h00);
        wr(8'h08, 32'hFF);
        pin = 8'hAA;
        repeat (10) tick();
        wr(8'h0C, 32'hFF);
        pin = 8'h00;
        repeat (10) tick();
        rdreg(8'h0C, rd, ak);
        checks++;
        if (rd !== 32'hAA || irq_o !== 1'b1) begin
            failures++;
            $display("FAIL fall_pend got=%h irq=%b expected AA irq=1", rd, irq_o);
        end
        wr(8'h0C, 32'h0A);
        rdreg(8'h0C, rd, ak);
        checks++;
        if (rd !== 32'hA0 || irq_o !== 1'b1) begin
            failures++;
            $display("FAIL w1c_partial got=%h irq=%b expected A0 irq=1", rd, irq_o);
        end
        wr(8'h0C, 32'hA0);
        checks++;
        if (irq_o !== 1'b0) begin
            failures++;
            $display("FAIL w1c_all irq=%b expected 0", irq_o);
        end
        wr(8'h08, 32'h00);
    endtask

    task automatic test_collision();
        logic [31:0] rd, ex;
        logic ak;
        wr(8'h04, 32'h04);
        pin[2] = 1'b1;
        repeat (3) tick();
        bus(1'b1, 8'h0C, 32'h04, rd, ak, ex);
        rdreg(8'h0C, rd, ak);
        checks++;
        if (rd !== 32'h04 || m_pend !== 8'h04) begin
            failures++;
            $display("FAIL set_beats_clear pend=%h model=%h expected 04", rd, m_pend);
        end
        wr(8'h0C, 32'h04);
        rdreg(8'h0C, rd, ak);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL clear_after_collision pend=%h expected 00", rd);
        end
    endtask

    task automatic test_unmapped_and_reset();
        logic [31:0] rd;
        logic ak;
        logic [7:0] regs [5] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10};
        rdreg(8'h1C, rd, ak);
        checks++;
        if (ak !== 1'b1 || rd !== 32'h0 || ack_o !== 1'b0) begin
            failures++;
            $display("FAIL unmapped_read ack=%b dat=%h ack_after=%b expected 1 0 0", ak, rd, ack_o);
        end
        wr(8'h1C, 32'hFFFF_FFFF);
        rdreg(8'h04, rd, ak);
        checks++;
        if (rd !== 32'h04) begin
            failures++;
            $display("FAIL unmapped_write rise_en=%h expected 04", rd);
        end
        wr(8'h10, 32'd10);
        wr(8'h04, 32'hFF);
        pin = 8'h05;
        repeat (7) tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 8'h04;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({ack_o, irq_o, dat_o} !== 34'h0) begin
            failures++;
            $display("FAIL reset_async ack=%b irq=%b dat=%h expected all 0", ack_o, irq_o, dat_o);
        end
        pin = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (ack_o !== 1'b0) begin
            failures++;
            $display("FAIL aborted_ack ack=%b expected 0", ack_o);
        end
        foreach (regs[i]) begin
            rdreg(regs[i], rd, ak);
            checks++;
            if (rd !== 32'h0) begin
                failures++;
                $display("FAIL post_reset_reg_%h got=%h expected 0", regs[i], rd);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, ex;
        logic ak;
        logic [7:0] addrs [6] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};
        wr(8'h10, 32'($urandom_range(3, 0)));
        wr(8'h04, 32'($urandom_range(255, 0)));
        wr(8'h08, 32'($urandom_range(255, 0)));
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(5, 0) == 0) begin
                int b = $urandom_range(7, 0);
                pin[b] = ~pin[b];
            end
            case ($urandom_range(11, 0))
                0, 1: begin
                    logic [7:0] a = addrs[$urandom_range(5, 0)];
                    bus(1'b0, a, 32'h0, rd, ak, ex);
                    checks++;
                    if (ak !== 1'b1 || rd !== ex) begin
                        failures++;
                        $display("FAIL rand_read_%h it=%0d ack=%b got=%h expected %h", a, it, ak, rd, ex);
                    end
                end
                2: bus(1'b1, 8'h0C, 32'($urandom_range(255, 0)), rd, ak, ex);
                3: if ($urandom_range(7, 0) == 0) bus(1'b1, 8'h10, 32'($urandom_range(5, 0)), rd, ak, ex);
                default: begin
                    tick();
                    checks++;
                    if (irq_o !== (m_pend != 8'h00)) begin
                        failures++;
                        $display("FAIL rand_irq it=%0d got=%b model_pend=%h", it, irq_o, m_pend);
                    end
                end
            endcase
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_rise_db0();
        test_debounce_glitch();
        test_w1c();
        test_collision();
        test_unmapped_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/gpio_edge_irq.md
GPIO_EDGE_IRQ -- requirements
Module: gpio_edge_irq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of sampled GPIO input pins.
REQ-002 SHALL have parameter DB_W, default 16, meaning the debounce counter width.
REQ-003 SHALL have port clk, input, 1: the single clock; all flops are rising-edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port pin_i, input, WIDTH: asynchronous pad receive values.
REQ-006 SHALL have ports cyc_i and stb_i, input, 1 each: bus cycle and strobe.
REQ-007 SHALL have port we_i, input, 1: bus write enable.
REQ-008 SHALL have port addr_i, input, 8: byte address; bits [1:0] are ignored.
REQ-009 SHALL have port dat_i, input, 32: bus write data.
REQ-010 SHALL have port dat_o, output, 32: bus read data.
REQ-011 SHALL have port ack_o, output, 1: bus acknowledge.
REQ-012 SHALL have port irq_o, output, 1: level interrupt request.

Function
REQ-013 SHALL pass each pin_i bit through a two-flop synchronizer to produce sync[i].
REQ-014 SHALL keep a per-pin debounce counter cnt[i] and stable value stb_v[i].
- sync==stb_v: cnt clears to 0.
- sync!=stb_v and cnt>=DB_CNT: stb_v<=sync and cnt<=0.
- Otherwise: cnt increments, saturating at all-ones.
REQ-015 SHALL update stb_v exactly DB_CNT+1 cycles after sync first differs, provided sync does not revert in between; DB_CNT=0 therefore gives a 1-cycle debounce.
REQ-016 SHALL restart the count from 0 whenever sync reverts to stb_v before the threshold is reached.
REQ-017 SHALL take effect immediately when DB_CNT is rewritten mid-count; the >= compare releases any counter already above the new value on the next cycle.
REQ-018 SHALL detect a rise (stb_v 0->1) or fall (1->0) and set PEND[i] on the cycle after stb_v changes, if RISE_EN[i] or FALL_EN[i] respectively is 1.
REQ-019 SHALL provide this register map:
- 0x00 IN: RO, stb_v.
- 0x04 RISE_EN: RW.
- 0x08 FALL_EN: RW.
- 0x0C PEND: RW1C.
- 0x10 DB_CNT: RW, DB_W bits.
REQ-020 SHALL let an edge set and a W1C clear of the same PEND bit in the same cycle resolve with set winning.
REQ-021 SHALL drive irq_o as the OR of all PEND bits, with no added latency beyond the PEND flops.
REQ-022 SHALL accept a transfer when cyc_i&stb_i&!ack_o, assert ack_o for exactly one cycle on the following cycle, and hold dat_o valid during ack_o.
REQ-023 SHALL drive dat_o to 0 when ack_o is low.
REQ-024 SHALL read unused register bits as 0.
REQ-025 SHALL ack accesses to unmapped addresses, return 0 on read, and ignore writes.
REQ-026 SHALL NOT let a write to RISE_EN or FALL_EN alter existing PEND bits.

Reset
REQ-027 SHALL clear to 0 on rst_n low, asynchronously: synchronizer flops, stb_v, cnt, RISE_EN, FALL_EN, PEND, DB_CNT, ack_o, dat_o, irq_o.
REQ-028 SHALL abort any in-flight debounce or bus transfer on reset assertion; no ack_o for the aborted transfer.
REQ-029 SHALL not generate an edge on the first sample after reset release if pins are high; a pin that is 1 at release produces a rise after debounce, by design.

Structure
REQ-030 SHALL place register offsets, the default WIDTH and DB_W, and an access-type enum in package gpio_irq_pkg.
REQ-031 SHALL implement the synchronizer, counter and stb_v of one pin in sub-module gpio_irq_debounce, instantiated WIDTH times via generate.

Verification
REQ-032 SHALL verify: DB_CNT=0, RISE_EN=0x01, pin_i[0] 0->1 -> IN=0x01 and PEND=0x01 within 4 cycles of the pin change; irq_o=1.
REQ-033 SHALL verify: DB_CNT=10, pin_i[3] pulses high for 5 cycles -> IN and PEND stay 0; then held high 20 cycles -> IN=0x08 at 2+11 cycles after the hold starts.
REQ-034 SHALL verify: FALL_EN=0xFF, pin_i 0xAA->0x00 after settle -> PEND=0xAA; write 0x0C with 0x0A -> PEND=0xA0, irq_o still 1; write 0xA0 -> irq_o=0.
REQ-035 SHALL verify: a W1C of PEND bit 2 lands in the same cycle as a qualified edge on pin 2 -> PEND[2] remains 1.
REQ-036 SHALL verify: read 0x1C -> ack_o one cycle after strobe, dat_o=0; reset asserted mid-debounce (cnt=5) -> all registers read 0 after release.
